// File: rtl/sram_obi_bank_ctrl_pkg.sv
// Shared types for the OBI-to-SRAM bank controller: FSM state encoding and
// the byte-to-word address offset.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        RET   = 3'd3,
        WAKE  = 3'd4
    } sram_ctrl_state_e;

    localparam int unsigned WordOffset = 2;

endpackage

// File: rtl/sram_obi_bank_ctrl.sv
// OBI slave front-end for one SRAM bank: zero-fill after reset, word-addressed
// pass-through with a one-cycle response, and the retention entry/exit handshake.
module sram_obi_bank_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned NumWords    = 8192,
    parameter int unsigned DataWidth   = 32,
    parameter bit          InitOnReset = 1'b1,
    parameter int unsigned WakeCycles  = 2,
    parameter int unsigned AddrWidth   = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    input  logic                 ret_req_i,
    output logic                 ret_ack_o,
    output logic                 init_done_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    output logic [3:0]           sram_be_o,
    output logic                 sram_set_retentive_no,
    input  logic [31:0]          sram_rdata_i
);

    localparam int unsigned WakeW = $clog2(WakeCycles + 1);
    localparam int unsigned CntW  = (AddrWidth > WakeW) ? AddrWidth : WakeW;

    if (DataWidth != 32) begin : g_bad_width
        $error("sram_obi_bank_ctrl supports DataWidth = 32 only");
    end

    sram_ctrl_state_e     r_state;
    logic [CntW-1:0]      r_cnt;
    logic                 r_init_done;
    logic                 r_ret_ack;
    logic                 r_set_ret_n;
    logic                 r_rvalid;
    logic                 r_rd;

    logic                 w_gnt;
    logic                 w_sram_req;
    logic                 w_sram_we;
    logic [AddrWidth-1:0] w_sram_addr;
    logic [31:0]          w_sram_wdata;
    logic [3:0]           w_sram_be;
    logic                 w_unused;

    // Ignored byte-lane and aliasing address bits.
    assign w_unused = ^{addr_i[31:AddrWidth+WordOffset], addr_i[WordOffset-1:0]};

    // Grant decode and SRAM request steering (sweep writes vs. granted bus requests).
    always_comb begin
        w_gnt        = 1'b0;
        w_sram_req   = 1'b0;
        w_sram_we    = 1'b0;
        w_sram_addr  = '0;
        w_sram_wdata = 32'h0000_0000;
        w_sram_be    = 4'h0;
        case (r_state)
            INIT: begin
                // Keep the SRAM port quiet while reset is held.
                if (rst_ni) begin
                    w_sram_req  = 1'b1;
                    w_sram_we   = 1'b1;
                    w_sram_be   = 4'hF;
                    w_sram_addr = r_cnt[AddrWidth-1:0];
                end else begin
                    w_sram_req  = 1'b0;
                end
            end
            RUN: begin
                w_gnt = req_i & ~ret_req_i;
                if (w_gnt) begin
                    w_sram_req   = 1'b1;
                    w_sram_we    = we_i;
                    w_sram_be    = be_i;
                    w_sram_wdata = wdata_i;
                    w_sram_addr  = addr_i[AddrWidth+WordOffset-1:WordOffset];
                end else begin
                    w_sram_req   = 1'b0;
                end
            end
            default: begin
                w_gnt = 1'b0;
            end
        endcase
    end

    // Control FSM, shared sweep/wake counter and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= InitOnReset ? INIT : RUN;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_ret_ack   <= 1'b0;
            r_set_ret_n <= 1'b1;
            r_rvalid    <= 1'b0;
            r_rd        <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_rd     <= w_gnt & ~we_i;
            case (r_state)
                INIT: begin
                    if (r_cnt == CntW'(NumWords - 1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                RUN: begin
                    r_init_done <= 1'b1;
                    if (ret_req_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state     <= RET;
                    r_set_ret_n <= 1'b0;
                    r_ret_ack   <= 1'b1;
                end
                RET: begin
                    if (!ret_req_i) begin
                        r_state     <= WAKE;
                        r_set_ret_n <= 1'b1;
                        r_cnt       <= CntW'(WakeCycles - 1);
                    end
                end
                WAKE: begin
                    // A re-asserted ret_req_i is picked up again from RUN.
                    if (r_cnt == '0) begin
                        r_state   <= RUN;
                        r_ret_ack <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign gnt_o                 = w_gnt;
    assign sram_req_o            = w_sram_req;
    assign sram_we_o             = w_sram_we;
    assign sram_addr_o           = w_sram_addr;
    assign sram_wdata_o          = w_sram_wdata;
    assign sram_be_o             = w_sram_be;
    assign sram_set_retentive_no = r_set_ret_n;
    assign ret_ack_o             = r_ret_ack;
    assign init_done_o           = r_init_done;
    assign rvalid_o              = r_rvalid;
    assign rdata_o               = r_rd ? sram_rdata_i : 32'h0000_0000;

endmodule

// File: tb/tb_sram_obi_bank_ctrl.sv
// Directed self-checking bench for sram_obi_bank_ctrl with a behavioural SRAM bank.
module tb_sram_obi_bank_ctrl;

    localparam int unsigned NW = 8192;
    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req, we, ret_req;
    logic [31:0]   addr, wdata;
    logic [3:0]    be;
    logic          gnt, rvalid, ret_ack, init_done;
    logic [31:0]   rdata;
    logic          s_req, s_we, s_ret_n;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata, s_rdata;
    logic [3:0]    s_be;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] mem [0:NW-1];

    always #5 clk = ~clk;

    sram_obi_bank_ctrl #(
        .NumWords(NW), .DataWidth(32), .InitOnReset(1'b1), .WakeCycles(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata),
        .ret_req_i(ret_req), .ret_ack_o(ret_ack), .init_done_o(init_done),
        .sram_req_o(s_req), .sram_we_o(s_we), .sram_addr_o(s_addr),
        .sram_wdata_o(s_wdata), .sram_be_o(s_be),
        .sram_set_retentive_no(s_ret_n), .sram_rdata_i(s_rdata)
    );

    // Behavioural SRAM: byte-enabled writes, read data valid the following cycle.
    always_ff @(posedge clk) begin
        if (s_req) begin
            if (s_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_be[b]) mem[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end else begin
                s_rdata <= mem[s_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {gnt, sram_req, we, be, wdata, addr, init_done} for one sweep word.
    function automatic logic [63:0] sweep_vec(input logic [AW-1:0] a);
        return {11'd0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0, a, 1'b0};
    endfunction

    task automatic idle_bus();
        req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    endtask

    logic [31:0] rd_addr [3];
    logic [31:0] rd_exp  [3];

    initial begin
        rst_n = 1'b0; ret_req = 1'b0;
        idle_bus();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rvalid",    64'(rvalid),    64'd0);
        chk("rst_ret_ack",   64'(ret_ack),   64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_ret_n",     64'(s_ret_n),   64'd1);
        chk("rst_sram_req",  64'(s_req),     64'd0);
        chk("rst_gnt",       64'(gnt),       64'd0);

        // Partial sweep, then reset at word 100.
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            #1;
            chk("sweep_a", {11'd0, gnt, s_req, s_we, s_be, s_wdata, s_addr, init_done},
                sweep_vec(AW'(i)));
            if (i < 100) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_sram_req", 64'(s_req), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full sweep restarts from word 0.
        for (int i = 0; i < int'(NW); i++) begin
            #1;
            chk("sweep_b", {11'd0, gnt, s_req, s_we, s_be, s_wdata, s_addr, init_done},
                sweep_vec(AW'(i)));
            @(negedge clk);
        end
        #1;
        chk("init_done_up", 64'(init_done), 64'd1);
        chk("post_sweep_req", 64'(s_req), 64'd0);

        // Partial-byte write then read of 0x40.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h40; be = 4'b0101; wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_gnt", 64'(gnt), 64'd1);
        chk("wr_sram", {s_req, s_we, s_be, s_wdata, 6'd0, s_addr},
            {1'b1, 1'b1, 4'b0101, 32'hDEAD_BEEF, 6'd0, 13'h010});
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h40; be = 4'hF; wdata = 32'h0;
        #1;
        chk("wr_rvalid", 64'(rvalid), 64'd1);
        chk("wr_rdata",  64'(rdata),  64'd0);
        chk("rd_gnt",    64'(gnt),    64'd1);
        @(negedge clk);
        idle_bus();
        #1;
        chk("rd_rvalid", 64'(rvalid), 64'd1);
        chk("rd_rdata",  64'(rdata),  64'h00AD_00EF);
        @(negedge clk);
        #1;
        chk("rd_rvalid_low", 64'(rvalid), 64'd0);

        // Seed words 1 and 2 back-to-back; word 2 via an aliased upper address bit.
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h4; wdata = 32'h1111_1111;
        @(negedge clk);
        addr = 32'h0001_0008; wdata = 32'h2222_2222;
        #1;
        chk("alias_addr", 64'(s_addr), 64'd2);
        @(negedge clk);
        idle_bus();

        // Back-to-back reads of 0x0, 0x4, 0x8.
        rd_addr[0] = 32'h0; rd_addr[1] = 32'h4; rd_addr[2] = 32'h8;
        rd_exp[0]  = 32'h0; rd_exp[1]  = 32'h1111_1111; rd_exp[2] = 32'h2222_2222;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) begin
                req = 1'b1; we = 1'b0; be = 4'hF; addr = rd_addr[k];
            end else begin
                idle_bus();
            end
            #1;
            if (k < 3) chk("b2b_gnt", 64'(gnt), 64'd1);
            if (k > 0) begin
                chk("b2b_rvalid", 64'(rvalid), 64'd1);
                chk("b2b_rdata",  64'(rdata),  64'(rd_exp[k-1]));
            end
        end

        // req and ret_req together: no grant, DRAIN, then RET.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h40; be = 4'hF; ret_req = 1'b1;
        #1;
        chk("ret_no_gnt",  64'(gnt),   64'd0);
        chk("ret_no_sreq", 64'(s_req), 64'd0);
        @(negedge clk);
        #1;
        chk("drain_gnt_ack", {gnt, rvalid, ret_ack, s_ret_n}, {1'b0, 1'b0, 1'b0, 1'b1});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("ret_state", {gnt, s_req, ret_ack, s_ret_n}, {1'b0, 1'b0, 1'b1, 1'b0});
        end
        ret_req = 1'b0;

        // Two WAKE cycles, then RUN and a read of prior data.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("wake_state", {gnt, s_req, ret_ack, s_ret_n}, {1'b0, 1'b0, 1'b1, 1'b1});
        end
        @(negedge clk);
        #1;
        chk("run_after_wake", {gnt, s_req, ret_ack, s_ret_n}, {1'b1, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        idle_bus();
        #1;
        chk("wake_rd_rvalid", 64'(rvalid), 64'd1);
        chk("wake_rd_rdata",  64'(rdata),  64'h00AD_00EF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
